// File: rtl/psum_collector_if.sv
// Capture and output-row signals of the partial-sum collector.
// The collector takes the slave side; whoever feeds it and drains the rows takes the master side.
interface psum_collector_if #(
  parameter int WORDWIDTH = 8,
  parameter int COLS      = 4
);
  localparam int PSW = WORDWIDTH * 4;

  logic [COLS-1:0]     enable_in;
  logic [COLS*PSW-1:0] ps_in;
  logic                out_valid;
  logic                out_ready;
  logic [COLS*PSW-1:0] out_data;

  modport master (
    output enable_in,
    output ps_in,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  enable_in,
    input  ps_in,
    input  out_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/psum_collector.sv
// Per-column deskew FIFOs for the systolic array's bottom-row partial sums.
// Once every column holds an entry, their heads are popped together into one registered output row.
module psum_collector #(
  parameter int WORDWIDTH = 8,
  parameter int COLS      = 4,
  parameter int DEPTH     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  psum_collector_if.slave     bus,
  output logic                overflow,
  output logic [15:0]         row_count
);
  localparam int PSW = WORDWIDTH * 4;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);

  logic [PSW-1:0]      mem_r      [COLS][DEPTH];
  logic [AW-1:0]       wr_ptr_r   [COLS];
  logic [AW-1:0]       rd_ptr_r   [COLS];
  logic [CW-1:0]       occ_r      [COLS];
  logic [COLS-1:0]     push_s;
  logic [COLS-1:0]     drop_s;
  logic [COLS-1:0]     nonempty_s;
  logic [COLS*PSW-1:0] head_s;
  logic                all_ne_s;
  logic                load_s;
  logic                accept_s;
  logic [COLS*PSW-1:0] out_data_r;
  logic                out_valid_r;
  logic                overflow_r;
  logic [15:0]         row_count_r;

  // A full column may still take a sample when the row load pops it in the same edge.
  always_comb begin
    push_s     = '0;
    drop_s     = '0;
    nonempty_s = '0;
    head_s     = '0;
    for (int c = 0; c < COLS; c++) begin
      nonempty_s[c]          = (occ_r[c] != '0);
      head_s[c*PSW +: PSW]   = mem_r[c][rd_ptr_r[c]];
    end
    all_ne_s = &nonempty_s;
    load_s   = all_ne_s && (!out_valid_r || bus.out_ready);
    accept_s = out_valid_r && bus.out_ready;
    for (int c = 0; c < COLS; c++) begin
      if (bus.enable_in[c]) begin
        if ((occ_r[c] != FULL_OCC) || load_s) begin
          push_s[c] = 1'b1;
        end else begin
          drop_s[c] = 1'b1;
        end
      end else begin
        push_s[c] = 1'b0;
        drop_s[c] = 1'b0;
      end
    end
  end

  // Storage carries no reset; the pointers and occupancies define what is valid.
  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int c = 0; c < COLS; c++) begin
        if (push_s[c]) begin
          mem_r[c][wr_ptr_r[c]] <= bus.ps_in[c*PSW +: PSW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < COLS; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        occ_r[c]    <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < COLS; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        occ_r[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (push_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + AW'(1'b1);
        end
        if (load_s) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + AW'(1'b1);
        end
        occ_r[c] <= occ_r[c] + CW'(push_s[c]) - CW'(load_s);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      overflow_r  <= 1'b0;
      row_count_r <= 16'd0;
    end else if (clear) begin
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      row_count_r <= 16'd0;
    end else begin
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= head_s;
      end else if (accept_s) begin
        out_valid_r <= 1'b0;
      end
      if (|drop_s) begin
        overflow_r <= 1'b1;
      end
      if (accept_s) begin
        row_count_r <= row_count_r + 16'd1;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign overflow      = overflow_r;
  assign row_count     = row_count_r;
endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: expected rows are queued when driven and
// compared whenever the output handshake completes.
module tb_psum_collector;
  localparam int WORDWIDTH = 8;
  localparam int COLS      = 4;
  localparam int DEPTH     = 4;
  localparam int PSW       = WORDWIDTH * 4;
  localparam int RW        = COLS * PSW;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        overflow;
  logic [15:0] row_count;

  int vectors;
  int miscompares;
  logic [RW-1:0] sb[$];

  psum_collector_if #(.WORDWIDTH(WORDWIDTH), .COLS(COLS)) bus ();

  psum_collector #(.WORDWIDTH(WORDWIDTH), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bus       (bus),
    .overflow  (overflow),
    .row_count (row_count)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] mkrow(input int base);
    logic [RW-1:0] r;
    r = '0;
    for (int c = 0; c < COLS; c++) r[c*PSW +: PSW] = PSW'(base + c);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check any handshake at the falling edge, then return #1 after the rising edge.
  task automatic step();
    logic [RW-1:0] e;
    @(negedge clk);
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("row_expected", RW'(sb.size() != 0), RW'(1'b1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("row_data", bus.out_data, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input int base);
    bus.enable_in = {COLS{1'b1}};
    bus.ps_in     = mkrow(base);
  endtask

  task automatic idle(input int n);
    bus.enable_in = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [RW-1:0] tmp;
    clk = 1'b0; reset = 1'b1; clear = 1'b0;
    vectors = 0; miscompares = 0;
    bus.enable_in = '0; bus.ps_in = '0; bus.out_ready = 1'b1;
    #12;
    chk("rst_valid", RW'(bus.out_valid), RW'(0));
    chk("rst_data", bus.out_data, RW'(0));
    chk("rst_ovf", RW'(overflow), RW'(0));
    chk("rst_count", RW'(row_count), RW'(0));
    @(posedge clk); #1; reset = 1'b0;

    // aligned stream
    for (int r = 0; r < 3; r++) begin
      drive_row(10 * r); sb.push_back(mkrow(10 * r)); step();
      if (r == 0) chk("aligned_lat0", RW'(bus.out_valid), RW'(0));
      if (r == 1) chk("aligned_lat1", RW'(bus.out_valid), RW'(1));
    end
    idle(4);
    chk("aligned_count", RW'(row_count), RW'(3));
    chk("aligned_drained", RW'(sb.size()), RW'(0));

    // skewed stream: column c active for cycles c..c+3
    for (int r = 0; r < 4; r++) sb.push_back(mkrow(100 + 10 * r));
    for (int t = 0; t < 7; t++) begin
      tmp = '0;
      for (int c = 0; c < COLS; c++) begin
        bus.enable_in[c] = (t >= c) && (t < c + 4);
        tmp[c*PSW +: PSW] = PSW'(100 + 10 * (t - c) + c);
      end
      bus.ps_in = tmp;
      step();
      if (t == 3) chk("skew_lat0", RW'(bus.out_valid), RW'(0));
      if (t == 4) chk("skew_lat1", RW'(bus.out_valid), RW'(1));
    end
    idle(4);
    chk("skew_ovf", RW'(overflow), RW'(0));
    chk("skew_count", RW'(row_count), RW'(7));
    chk("skew_drained", RW'(sb.size()), RW'(0));

    // backpressure: six rows offered while stalled, the sixth is dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_row(200 + 10 * i);
      if (i < 5) sb.push_back(mkrow(200 + 10 * i));
      step();
      if (i >= 1) begin
        chk("bp_hold_valid", RW'(bus.out_valid), RW'(1));
        chk("bp_hold_data", bus.out_data, mkrow(200));
      end
      if (i == 4) chk("bp_no_ovf_yet", RW'(overflow), RW'(0));
    end
    chk("bp_ovf", RW'(overflow), RW'(1));
    bus.out_ready = 1'b1;
    idle(8);
    chk("bp_count", RW'(row_count), RW'(12));
    chk("bp_drained", RW'(sb.size()), RW'(0));
    chk("bp_ovf_sticky", RW'(overflow), RW'(1));

    // flush before the full-with-pop case
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_ovf", RW'(overflow), RW'(0));
    chk("clr_count", RW'(row_count), RW'(0));

    // full FIFOs, output register held, then push during pop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_row(300 + 10 * i); sb.push_back(mkrow(300 + 10 * i)); step();
    end
    bus.out_ready = 1'b1;
    drive_row(350); sb.push_back(mkrow(350)); step();
    chk("fullpop_ovf", RW'(overflow), RW'(0));
    chk("fullpop_data", bus.out_data, mkrow(310));
    idle(8);
    chk("fullpop_count", RW'(row_count), RW'(6));
    chk("fullpop_drained", RW'(sb.size()), RW'(0));

    // clear with two rows pending behind the output register
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_row(400 + 10 * i); step();
    end
    bus.enable_in = '0;
    clear = 1'b1; step(); clear = 1'b0;
    chk("mclr_valid", RW'(bus.out_valid), RW'(0));
    chk("mclr_count", RW'(row_count), RW'(0));
    chk("mclr_ovf", RW'(overflow), RW'(0));
    bus.out_ready = 1'b1;
    drive_row(430); sb.push_back(mkrow(430)); step();
    idle(4);
    chk("mclr_single_count", RW'(row_count), RW'(1));
    chk("mclr_drained", RW'(sb.size()), RW'(0));

    // asynchronous reset between edges
    bus.out_ready = 1'b0;
    drive_row(500); step();
    drive_row(510); step();
    bus.enable_in = '0;
    chk("arst_pre_valid", RW'(bus.out_valid), RW'(1));
    #2; reset = 1'b1; #1;
    chk("arst_valid", RW'(bus.out_valid), RW'(0));
    chk("arst_data", bus.out_data, RW'(0));
    chk("arst_count", RW'(row_count), RW'(0));
    reset = 1'b0;
    bus.out_ready = 1'b1;
    drive_row(520); sb.push_back(mkrow(520)); step();
    idle(4);
    chk("arst_single_count", RW'(row_count), RW'(1));
    chk("arst_drained", RW'(sb.size()), RW'(0));

    // long stream to reach the row_count wrap
    for (int i = 0; i < 65534; i++) begin
      drive_row(4 * i); sb.push_back(mkrow(4 * i)); step();
    end
    idle(4);
    chk("wrap_ffff", RW'(row_count), RW'(16'hFFFF));
    drive_row(7000); sb.push_back(mkrow(7000)); step();
    idle(4);
    chk("wrap_zero", RW'(row_count), RW'(16'h0000));
    chk("wrap_drained", RW'(sb.size()), RW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
